// File: rtl/alu_result_stage.sv
// alu_result_stage: multi-cycle capture stage that sits directly after the ALU.
// Latency: Z captured ALU_WAIT (or MULDIV_WAIT for mul/div) edges after start; mul/div add one COMMIT cycle for HI/LO.
// Backpressure: none; start is ignored while busy and requests are never queued.
//
// Ports:
//   clock       - system clock, all state updates on the rising edge
//   clear       - synchronous active-high reset, aborts any operation in flight
//   start       - request; accepted only in IDLE or DONE
//   opcode      - ALU opcode, held stable by upstream until done
//   alu_c       - 64-bit combinational ALU result
//   busy        - high while in WAIT or COMMIT
//   done        - one-cycle completion pulse
//   illegal_op  - qualifies done when the accepted opcode was illegal
//   z_hi, z_lo  - captured Z register pair
//   hi_out, lo_out - HI/LO registers, written only by mul/div
//
// Optional build macro ALU_RESULT_FLAGS_EN adds zero_flag / neg_flag outputs,
// registered at the Z capture edge.

module alu_result_stage #(
  parameter int unsigned ALU_WAIT    = 1,
  parameter int unsigned MULDIV_WAIT = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic [63:0] alu_c,
  output logic        busy,
  output logic        done,
  output logic        illegal_op,
  output logic [31:0] z_hi,
  output logic [31:0] z_lo,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
`ifdef ALU_RESULT_FLAGS_EN
  ,
  output logic        zero_flag,
  output logic        neg_flag
`endif
);

  // Counter only ever holds W-1 down to 0, so size it for the larger wait.
  localparam int unsigned MAX_WAIT = (ALU_WAIT > MULDIV_WAIT) ? ALU_WAIT : MULDIV_WAIT;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

  localparam logic [CNT_W-1:0] ALU_LOAD    = CNT_W'(ALU_WAIT - 1);
  localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_COMMIT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [4:0]         op_q;
  logic [63:0]        z_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;
  logic               busy_q;
  logic               done_q;
  logic               illegal_q;
`ifdef ALU_RESULT_FLAGS_EN
  logic               zero_q;
  logic               neg_q;
  logic               zero_d;
  logic               neg_d;
`endif

  logic               accept;
  logic               op_legal;
  logic               op_muldiv_in;
  logic               op_muldiv_q;
  logic [CNT_W-1:0]   cnt_load_d;

  // IDLE and DONE are the only non-busy states, so acceptance is possible in both;
  // accepting in DONE gives back-to-back operation without an idle bubble.
  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Legal ranges are 3..10 and 12..18; 11 is a hole in the ALU encoding.
  assign op_legal = ((opcode >= 5'd3)  && (opcode <= 5'd10)) ||
                    ((opcode >= 5'd12) && (opcode <= 5'd18));

  assign op_muldiv_in = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign op_muldiv_q  = (op_q   == OP_MUL) || (op_q   == OP_DIV);

  assign cnt_load_d = op_muldiv_in ? MULDIV_LOAD : ALU_LOAD;

`ifdef ALU_RESULT_FLAGS_EN
  // Mul/div results are full 64-bit quantities for zero detection; single-word ops
  // only own the low half. Sign comes from the product MSB for mul, and from the
  // low word otherwise (quotient sign for div).
  always_comb begin
    zero_d = 1'b0;
    neg_d  = 1'b0;
    if (op_muldiv_q) begin
      zero_d = (alu_c == 64'd0);
    end else begin
      zero_d = (alu_c[31:0] == 32'd0);
    end
    if (op_q == OP_MUL) begin
      neg_d = alu_c[63];
    end else begin
      neg_d = alu_c[31];
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      z_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_RESULT_FLAGS_EN
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_q <= opcode;
            if (op_legal) begin
              state_q   <= S_WAIT;
              cnt_q     <= cnt_load_d;
              busy_q    <= 1'b1;
              done_q    <= 1'b0;
              illegal_q <= 1'b0;
            end else begin
              // Illegal ops short-circuit to DONE; Z/HI/LO are left untouched.
              state_q   <= S_DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              illegal_q <= 1'b1;
            end
          end else begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
          end
        end

        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            // Result has settled: capture all 64 bits, upper half included.
            z_q <= alu_c;
`ifdef ALU_RESULT_FLAGS_EN
            zero_q <= zero_d;
            neg_q  <= neg_d;
`endif
            if (op_muldiv_q) begin
              state_q <= S_COMMIT;
            end else begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end

        S_COMMIT: begin
          // For div the ALU packs remainder high and quotient low, so the
          // same split serves both mul and div.
          hi_q    <= z_q[63:32];
          lo_q    <= z_q[31:0];
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end

        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign illegal_op = illegal_q;
  assign z_hi       = z_q[63:32];
  assign z_lo       = z_q[31:0];
  assign hi_out     = hi_q;
  assign lo_out     = lo_q;
`ifdef ALU_RESULT_FLAGS_EN
  assign zero_flag  = zero_q;
  assign neg_flag   = neg_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed vectors with hand-computed expectations for alu_result_stage.
// Latency: inputs driven 1 time unit after each rising edge, outputs checked at the same point.
// Backpressure: n/a; all waits are fixed tick counts.

module tb_alu_result_stage;

  logic        clock;
  logic        clear;
  logic        start;
  logic [4:0]  opcode;
  logic [63:0] alu_c;
  logic        busy;
  logic        done;
  logic        illegal_op;
  logic [31:0] z_hi;
  logic [31:0] z_lo;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
`ifdef ALU_RESULT_FLAGS_EN
  logic        zero_flag;
  logic        neg_flag;
`endif

  int n_tests;
  int n_fail;
  int n_done;
  int n_busy;

  alu_result_stage #(
    .ALU_WAIT    (1),
    .MULDIV_WAIT (4)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .start      (start),
    .opcode     (opcode),
    .alu_c      (alu_c),
    .busy       (busy),
    .done       (done),
    .illegal_op (illegal_op),
    .z_hi       (z_hi),
    .z_lo       (z_lo),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
`ifdef ALU_RESULT_FLAGS_EN
    ,
    .zero_flag  (zero_flag),
    .neg_flag   (neg_flag)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear   = 1'b1;
    start   = 1'b0;
    opcode  = 5'd0;
    alu_c   = 64'd0;
    tick();
    tick();
    clear = 1'b0;

    // Reset state
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_ill", {63'd0, illegal_op}, 64'd0);
    check("rst_z", {z_hi, z_lo}, 64'd0);
    check("rst_hilo", {hi_out, lo_out}, 64'd0);

    // Single-word op: busy one cycle, then done with Z = 7
    opcode = 5'b00011;
    alu_c  = 64'h0000_0000_0000_0007;
    start  = 1'b1;
    tick();                       // E0
    start = 1'b0;
    check("add_busy", {63'd0, busy}, 64'd1);
    check("add_nodone", {63'd0, done}, 64'd0);
    tick();                       // E0+1
    check("add_done", {63'd0, done}, 64'd1);
    check("add_busy_lo", {63'd0, busy}, 64'd0);
    check("add_z", {z_hi, z_lo}, 64'd7);
    check("add_hilo", {hi_out, lo_out}, 64'd0);
    check("add_ill", {63'd0, illegal_op}, 64'd0);
`ifdef ALU_RESULT_FLAGS_EN
    check("add_zf", {63'd0, zero_flag}, 64'd0);
    check("add_nf", {63'd0, neg_flag}, 64'd0);
`endif
    tick();
    check("add_done_pulse", {63'd0, done}, 64'd0);

    // Mul: busy 5 cycles, Z at E0+4, HI/LO at E0+5 with done
    opcode = 5'b01111;
    alu_c  = 64'h0000_0001_FFFF_FFFE;
    start  = 1'b1;
    tick();                       // E0
    start  = 1'b0;
    n_busy = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy) n_busy++;
      tick();
    end
    // now after E0+3: Z still holds the previous result
    if (busy) n_busy++;
    check("mul_z_pre", {z_hi, z_lo}, 64'd7);
    tick();                       // E0+4
    if (busy) n_busy++;
    check("mul_z", {z_hi, z_lo}, 64'h0000_0001_FFFF_FFFE);
    check("mul_hilo_pre", {hi_out, lo_out}, 64'd0);
    check("mul_nodone", {63'd0, done}, 64'd0);
    tick();                       // E0+5
    if (busy) n_busy++;
    check("mul_busy_cnt", 64'(n_busy), 64'd5);
    check("mul_hi", {32'd0, hi_out}, 64'd1);
    check("mul_lo", {32'd0, lo_out}, 64'hFFFF_FFFE);
    check("mul_done", {63'd0, done}, 64'd1);
`ifdef ALU_RESULT_FLAGS_EN
    check("mul_zf", {63'd0, zero_flag}, 64'd0);
    check("mul_nf", {63'd0, neg_flag}, 64'd0);
`endif
    tick();

    // Div: remainder to HI, quotient to LO, done after W+1
    opcode = 5'b10000;
    alu_c  = {32'd3, 32'd5};
    start  = 1'b1;
    tick();                       // E0
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();   // E0+4
    check("div_nodone", {63'd0, done}, 64'd0);
    tick();                       // E0+5
    check("div_done", {63'd0, done}, 64'd1);
    check("div_hilo", {hi_out, lo_out}, {32'd3, 32'd5});
    tick();

    // Illegal opcode from non-zero Z: done+illegal next cycle, nothing written
    opcode = 5'b01011;
    alu_c  = 64'hDEAD_BEEF_0BAD_F00D;
    start  = 1'b1;
    tick();                       // E0
    start = 1'b0;
    check("ill_busy", {63'd0, busy}, 64'd0);
    check("ill_done", {63'd0, done}, 64'd1);
    check("ill_flag", {63'd0, illegal_op}, 64'd1);
    check("ill_z", {z_hi, z_lo}, {32'd3, 32'd5});
    check("ill_hilo", {hi_out, lo_out}, {32'd3, 32'd5});
    tick();
    check("ill_clr", {63'd0, illegal_op}, 64'd0);
    check("ill_done_pulse", {63'd0, done}, 64'd0);

    // Clear during the second WAIT cycle of a mul aborts everything
    opcode = 5'b01111;
    alu_c  = 64'hAAAA_BBBB_CCCC_DDDD;
    start  = 1'b1;
    tick();                       // E0
    start = 1'b0;
    tick();                       // E0+1
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_busy", {63'd0, busy}, 64'd0);
    check("clr_done", {63'd0, done}, 64'd0);
    check("clr_z", {z_hi, z_lo}, 64'd0);
    check("clr_hilo", {hi_out, lo_out}, 64'd0);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) n_done++;
    end
    check("clr_no_done", 64'(n_done), 64'd0);

    // Mul accepted, then a separate add request overlapping busy is ignored
    opcode = 5'b01111;
    alu_c  = 64'd5;
    start  = 1'b1;
    tick();                       // E0
    opcode = 5'b00011;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) start = 1'b0;
      tick();
      if (done) n_done++;
    end
    check("ovl_one_done", 64'(n_done), 64'd1);
    check("ovl_hilo", {hi_out, lo_out}, 64'd5);

    // Back-to-back: start held through DONE, second op accepted there
    opcode = 5'b00011;
    alu_c  = 64'h11;
    start  = 1'b1;
    tick();                       // E0 (accepted from IDLE)
    tick();                       // E0+1: first op DONE, start ignored in WAIT
    check("b2b_done1", {63'd0, done}, 64'd1);
    check("b2b_z1", {z_hi, z_lo}, 64'h11);
    alu_c = 64'h9;
    tick();                       // accepted in DONE
    start = 1'b0;
    check("b2b_busy2", {63'd0, busy}, 64'd1);
    check("b2b_nodone2", {63'd0, done}, 64'd0);
    tick();
    check("b2b_done2", {63'd0, done}, 64'd1);
    check("b2b_z2", {z_hi, z_lo}, 64'h9);

`ifdef ALU_RESULT_FLAGS_EN
    // Zero result sets zero_flag, then a negative low word sets neg_flag
    alu_c = 64'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("flg_zero", {63'd0, zero_flag}, 64'd1);
    check("flg_zero_nf", {63'd0, neg_flag}, 64'd0);
    alu_c = 64'h0000_0000_8000_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("flg_neg_zf", {63'd0, zero_flag}, 64'd0);
    check("flg_neg", {63'd0, neg_flag}, 64'd1);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Multi-cycle capture stage directly downstream of the ALU. Consumes the ALU's 64-bit combinational result C_out.
- Sequences an operation in three steps:
  - waits a programmable settling time (longer for mul/div, which are multicycle paths);
  - latches the result into the Z register pair;
  - for mul/div, commits the result to the HI/LO registers.
- Reports completion to the control unit with a done pulse and busy level.

Parameters:
- ALU_WAIT, 1, settling cycles for single-word ops; legal range >=1.
- MULDIV_WAIT, 4, settling cycles for mul (01111) and div (10000); legal range >=1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only when busy=0.
- opcode  in  5  ALU opcode, same encoding as the ALU. Upstream holds opcode and ALU operands stable until done.
- alu_c  in  64  ALU C_out.
- busy  out  1  high in WAIT and COMMIT.
- done  out  1  one-cycle pulse in the DONE state.
- illegal_op  out  1  high with done when the accepted opcode was illegal.
- z_hi  out  32  Z[63:32].
- z_lo  out  32  Z[31:0].
- hi_out  out  32  HI register.
- lo_out  out  32  LO register.

Behaviour:
- Reset: clear=1 at an edge forces the following, regardless of start or any in-flight operation:
  - state=IDLE;
  - z_hi, z_lo, hi_out, lo_out = 0;
  - busy=0, done=0, illegal_op=0;
  - internal counter = 0.
- Clear mid-operation aborts the operation; no done pulse is produced.
- Legal opcodes: 00011–01010 and 01100–10010. All others (00000–00010, 01011, 10011–11111) are illegal.
- States: IDLE, WAIT, COMMIT, DONE.
- Start acceptance: start is accepted in IDLE or DONE. This allows back-to-back operations without returning to IDLE. On acceptance:
  - opcode is latched;
  - W = MULDIV_WAIT for 01111/10000, otherwise ALU_WAIT;
  - counter loads W-1;
  - next state = WAIT.
- Illegal opcode on acceptance: next state = DONE with illegal_op=1. Z, HI and LO are unchanged.
- Start while busy=1 is ignored; no queuing.
- WAIT:
  - If counter != 0, the counter decrements.
  - If counter == 0: Z <= alu_c. Next state = COMMIT for mul/div, otherwise DONE.
- COMMIT (one cycle): hi_out <= z_hi and lo_out <= z_lo. Next state = DONE.
  - Mul: HI = product[63:32], LO = product[31:0].
  - Div: HI = remainder, LO = quotient.
- DONE (one cycle):
  - done=1;
  - illegal_op is registered alongside done;
  - next state = IDLE unless start is accepted.
- Latency, counted from the start-sampling edge E0:
  - Z updates at edge E0+W.
  - done is high in the cycle after E0+W for non-mul/div ops.
  - For mul/div, HI/LO update at E0+W+1 and done is high in the cycle after E0+W+1.
- Width rules: Z always receives all 64 bits of alu_c, including a zero upper half for single-word ops. HI/LO are written only by mul/div.
- Counter width: clog2(max(ALU_WAIT, MULDIV_WAIT)+1).

Optional Feature:
- Macro: ALU_RESULT_FLAGS_EN.
- When defined:
  - Adds outputs zero_flag and neg_flag, each 1 bit.
  - Both are registered at the Z capture edge and hold until the next capture or clear.
  - zero_flag: alu_c==0 for mul/div, alu_c[31:0]==0 otherwise.
  - neg_flag: alu_c[63] for mul, alu_c[31] otherwise. For div it is the quotient sign, alu_c[31].
  - Both flags are cleared by clear.
- When undefined: the ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Single-word op, defaults: opcode=00011, alu_c=64'h0000_0000_0000_0007, start pulse.
  - busy high for 1 cycle, then done.
  - z_lo=7, z_hi=0; hi_out/lo_out remain 0.
- Mul, MULDIV_WAIT=4: opcode=01111, alu_c=64'h0000_0001_FFFF_FFFE.
  - busy high 5 cycles; Z captured at E0+4.
  - hi_out=1, lo_out=FFFF_FFFE at E0+5; done in the following cycle.
- Div: opcode=10000, alu_c={32'd3,32'd5}.
  - hi_out=3 (remainder), lo_out=5 (quotient); done after W+1 cycles.
- Illegal opcode 01011, start from a non-zero Z.
  - done and illegal_op high in the next cycle; busy never asserts.
  - Z, HI and LO are unchanged.
- Clear asserted during the second WAIT cycle of a mul.
  - At the next edge all outputs are 0 and state is IDLE; no done pulse.
  - A subsequent start that overlaps busy on a separate op is ignored; no second done.
- Back-to-back: start held high through DONE with a new add opcode and alu_c=64'h9.
  - The second op is accepted in the DONE cycle.
  - Its done follows ALU_WAIT cycles later with z_lo=9.
  - With ALU_RESULT_FLAGS_EN, alu_c=0 gives zero_flag=1 and neg_flag=0.
